tm_rs_encoder: RTL
==================

# tm_rs_encoder

Systematic CCSDS Reed-Solomon RS(255,223) encoder (E=16, interleave depth 1) for the TTC telemetry downlink chain. It sits directly downstream of the TM CRC-32 stage and takes its 223-byte CRC-terminated frames. Each message byte passes through with one cycle of latency, then 32 parity bytes are appended, giving a 255-byte codeword for the ASM/randomizer stage.

## Interface
Parameters:
- MSG_LEN, 223: message bytes per codeword. Legal range 1..223; values below 223 give a shortened code with virtual zero fill.
- DUAL_BASIS, 1: 1 = dual-basis symbols at both ports (CCSDS 131.0-B transform T and T⁻¹ applied inside the block); 0 = conventional basis throughout.

Ports:
- ClkI_Dec8  in  1  byte clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- En_DataI  in  1  input byte valid
- DataI  in  8  input message byte
- En_DataO  out  1  output byte valid
- DataO  out  8  output byte (message, then parity)
- Err_Ovr  out  1  sticky overrun flag; cleared only by Rst

## Operation
- Field GF(2⁸), field polynomial x⁸+x⁷+x²+x+1 (0x187). Generator g(x)=∏(x−α^(11j)) for j=112..143, α=0x02. The 33 coefficients are constants derived offline: g0=g32=1, and the coefficients are palindromic (gi=g32−i).
- Parity register P[0..31] holds bytes and resets to 0.
- State MSG, counter cnt = 0..MSG_LEN−1:
  - On a cycle with En_DataI=1: fb = d ^ P[31], where d = DataI converted to conventional basis if DUAL_BASIS.
  - P[i] ← P[i−1] ^ gf_mul(fb, gi), for i = 31..1. P[0] ← gf_mul(fb, g0).
  - DataO ← DataI unchanged. En_DataO ← 1. cnt ← cnt+1.
  - After byte cnt = MSG_LEN−1: go to PAR and set cnt ← 0.
- State MSG, cycle with En_DataI=0: hold P and cnt. En_DataO ← 0, DataO ← 0. Gaps inside a message are legal.
- State PAR, cnt = 0..31, one byte every cycle regardless of En_DataI:
  - DataO ← P[31], converted to dual basis if DUAL_BASIS. En_DataO ← 1.
  - P shifts up: P[i] ← P[i−1], P[0] ← 0.
  - After cnt = 31: go to MSG, cnt ← 0. P is then all zero with no explicit clear.
- Overrun: if En_DataI=1 in any PAR cycle, that input byte is discarded and Err_Ovr ← 1. Encoding and parity output are unaffected.
- Source contract: at least 32 idle cycles after the last byte of each message. The upstream CRC stage needs 1 cycle, so the frame source upstream of it must also honour this gap.
- Arithmetic: gf_mul is combinational and reduces modulo 0x187. All XORs are 8-bit. No carries anywhere.

## Timing
- Reset values: En_DataO=0, DataO=0x00, Err_Ovr=0, state=MSG, cnt=0, P all 0x00.
- Rst asserted mid-frame aborts the codeword: outputs go to reset values immediately, and the first En_DataI byte after release is message byte 0.
- Latency: an input byte sampled at edge t appears on DataO/En_DataO after edge t (valid for the t→t+1 cycle). Outputs are registered only.
- Last message byte sampled at edge t:
  - Parity byte 0 (coefficient of x³¹) is registered at edge t+1.
  - Parity byte 31 is registered at edge t+32.
  - En_DataO falls after edge t+33 unless new data is valid.
- With contiguous input, En_DataO stays high for exactly 255 consecutive cycles.
- The first byte of the next message may be sampled at edge t+33 at the earliest. At that edge the block is in MSG, so the byte is accepted with no overrun.

## Test plan
- All-zero 223-byte message, contiguous, DUAL_BASIS=0 → 255 cycles of En_DataO=1; DataO = 223 zeros then 32 zeros; Err_Ovr=0.
- 50 random messages with DUAL_BASIS=1, fed from the CRC stage model → every codeword matches the team golden RS model byte-for-byte, including the CCSDS 131.0-B test vector.
- Message with En_DataI deasserted for 5 cycles after byte 100 → En_DataO low for those 5 cycles; parity identical to the contiguous case.
- En_DataI=1 with DataI=0xAA at parity cycle 10 → byte dropped; parity bytes unchanged; Err_Ovr=1 until Rst.
- Rst pulsed after message byte 150, then a full fresh message → outputs 0 during reset; the new codeword matches the golden model with no residue from the aborted frame.
- MSG_LEN=100, random message → 100 pass-through bytes plus 32 parity bytes, equal to the golden model run with 123 leading zero bytes.

Source files
------------

// File: rtl/tm_rs_encoder.sv
// rtl/tm_rs_encoder.sv - CCSDS RS(255,223) systematic encoder, E=16, interleave depth 1
module tm_rs_encoder #(
    parameter int MSG_LEN    = 223,
    parameter bit DUAL_BASIS = 1'b1
) (
    input  logic       ClkI_Dec8,
    input  logic       Rst,
    input  logic       En_DataI,
    input  logic [7:0] DataI,
    output logic       En_DataO,
    output logic [7:0] DataO,
    output logic       Err_Ovr
);
    // Columns of the conventional-to-dual basis matrix T; conventional bit k maps to byte k.
    localparam logic [63:0] TAL = 64'h8def_ec86_fa99_af7b;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] toDual(input logic [7:0] c);
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < 8; k++)
            if (c[k]) d = d ^ TAL[8*k +: 8];
        return d;
    endfunction

    function automatic logic [63:0] dualInvCols();
        logic [63:0] cols;
        logic [7:0]  d;
        cols = '0;
        for (int x = 0; x < 256; x++) begin
            d = toDual(8'(x));
            for (int k = 0; k < 8; k++)
                if (d == 8'(1 << k)) cols[8*k +: 8] = 8'(x);
        end
        return cols;
    endfunction

    // Product of (x + alpha^(11j)) for j = 112..143; alpha^(11*112) = alpha^212.
    function automatic logic [263:0] genPoly();
        logic [263:0] g;
        logic [7:0]   root;
        logic [7:0]   a11;
        g       = '0;
        g[7:0]  = 8'd1;
        root    = 8'd1;
        a11     = 8'd1;
        for (int n = 0; n < 212; n++) root = gfMul(root, 8'd2);
        for (int n = 0; n < 11; n++)  a11  = gfMul(a11, 8'd2);
        for (int j = 0; j < 32; j++) begin
            for (int i = j + 1; i >= 1; i--)
                g[8*i +: 8] = g[8*(i-1) +: 8] ^ gfMul(g[8*i +: 8], root);
            g[7:0] = gfMul(g[7:0], root);
            root   = gfMul(root, a11);
        end
        return g;
    endfunction

    localparam logic [255:0] GPOLY = 256'(genPoly());
    localparam logic [63:0]  DINV  = dualInvCols();
    localparam logic [7:0]   LAST  = 8'(MSG_LEN - 1);

    function automatic logic [7:0] toConv(input logic [7:0] d);
        logic [7:0] c;
        c = '0;
        for (int k = 0; k < 8; k++)
            if (d[k]) c = c ^ DINV[8*k +: 8];
        return c;
    endfunction

    typedef enum logic {S_MSG, S_PAR} state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [255:0] par;
    logic [7:0]   dConv;
    logic [7:0]   fb;
    logic [7:0]   parOut;
    logic [255:0] parFb;

    always_comb begin
        dConv      = DUAL_BASIS ? toConv(DataI) : DataI;
        fb         = dConv ^ par[255:248];
        parOut     = DUAL_BASIS ? toDual(par[255:248]) : par[255:248];
        parFb      = '0;
        parFb[7:0] = gfMul(fb, GPOLY[7:0]);
        for (int i = 1; i < 32; i++)
            parFb[8*i +: 8] = par[8*(i-1) +: 8] ^ gfMul(fb, GPOLY[8*i +: 8]);
    end

    always_ff @(posedge ClkI_Dec8 or posedge Rst) begin
        if (Rst) begin
            state    <= S_MSG;
            cnt      <= '0;
            par      <= '0;
            En_DataO <= 1'b0;
            DataO    <= '0;
            Err_Ovr  <= 1'b0;
        end else begin
            case (state)
                S_MSG: begin
                    if (En_DataI) begin
                        par      <= parFb;
                        DataO    <= DataI;
                        En_DataO <= 1'b1;
                        if (cnt == LAST) begin
                            state <= S_PAR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        En_DataO <= 1'b0;
                        DataO    <= '0;
                    end
                end
                S_PAR: begin
                    // The shift leaves par all zero after the last parity byte.
                    DataO    <= parOut;
                    En_DataO <= 1'b1;
                    par      <= {par[247:0], 8'h00};
                    if (En_DataI) Err_Ovr <= 1'b1;
                    if (cnt == 8'd31) begin
                        state <= S_MSG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_MSG;
            endcase
        end
    end
endmodule
